// File: rtl/nibble_arb_pkg.sv
// Shared types and constants for the nibble-test resource arbiter and related schedulers.
package nibble_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int NIB_W  = 4;
    localparam int STAT_W = 8;

    // Saturating increment: a counter that reaches all-ones stays there.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or after pointer p, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  p,
    output logic            any,
    output logic [IDW-1:0]  win_id,
    output logic [NREQ-1:0] win_onehot
);

    logic [IDW-1:0] idx;

    always_comb begin
        any        = 1'b0;
        win_id     = '0;
        win_onehot = '0;
        idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = IDW'((int'(p) + i) % NREQ);
            if (!any && req[idx]) begin
                any             = 1'b1;
                win_id          = idx;
                win_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nibble_res_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered nibble-test resource (x = ~a[0]).
// Optional per-requester grant counters are enabled with NIBBLE_RES_ARBITER_STATS_EN.
module nibble_res_arbiter
    import nibble_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int RES_LAT = 1,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*NIB_W-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [0:3]            res_a,
    input  logic                  res_x,
    output logic                  rsp_valid,
    output logic                  rsp_x,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
`ifdef NIBBLE_RES_ARBITER_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] grant_cnt
`endif
);

    localparam int CW = (RES_LAT > 1) ? $clog2(RES_LAT) : 1;

    arb_state_t       state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win_q;
    logic [CW-1:0]    cnt;

    logic             any;
    logic [IDW-1:0]   win_id;
    logic [NREQ-1:0]  win_onehot;
    logic [NIB_W-1:0] win_nib;
    logic [IDW-1:0]   ptr_next;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req        (req),
        .p          (ptr),
        .any        (any),
        .win_id     (win_id),
        .win_onehot (win_onehot)
    );

    // Bit 4k+3 of the winner's slice lands on res_a[0].
    assign win_nib  = req_data[int'(win_id)*NIB_W +: NIB_W];
    assign ptr_next = (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);

    // Handshake: a requester holds req/req_data until it sees its gnt bit; a one-cycle
    // gnt means its nibble was captured, and rsp_valid (one cycle) carries rsp_x/rsp_id.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            win_q     <= '0;
            cnt       <= '0;
            gnt       <= '0;
            res_a     <= '0;
            rsp_valid <= 1'b0;
            rsp_x     <= 1'b0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            rsp_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (any) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        gnt   <= win_onehot;
                        res_a <= win_nib;
                        win_q <= win_id;
                        ptr   <= ptr_next;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        res_a <= '0;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= CW'(RES_LAT - 1);
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_x     <= res_x;
                        rsp_id    <= win_q;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NIBBLE_RES_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (gnt[k]) begin
                    grant_cnt[k*STAT_W +: STAT_W] <= sat_inc(grant_cnt[k*STAT_W +: STAT_W]);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_nibble_res_arbiter.sv
// Directed bench for nibble_res_arbiter with a behavioural model of the x = ~a[0] resource.
module tb_nibble_res_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ*4-1:0] req_data = '0;
    logic [NREQ-1:0] gnt;
    logic [0:3]      res_a;
    logic            res_x;
    logic            rsp_valid;
    logic            rsp_x;
    logic [1:0]      rsp_id;
    logic            busy;
`ifdef NIBBLE_RES_ARBITER_STATS_EN
    logic [NREQ*8-1:0] grant_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] nib;
        logic       exp_x;
    } vec_t;

    vec_t vecs[16];

    nibble_res_arbiter #(.NREQ(NREQ), .RES_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .res_a     (res_a),
        .res_x     (res_x),
        .rsp_valid (rsp_valid),
        .rsp_x     (rsp_x),
        .rsp_id    (rsp_id),
        .busy      (busy)
`ifdef NIBBLE_RES_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // clock / resource model
    always #5 clk = ~clk;

    always @(posedge clk) res_x <= ~res_a[0];

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // driver / checker tasks
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic single(input int k, input logic [3:0] nib, input logic exp_x, input string tag);
        bit ok;
        req[k] = 1'b1;
        req_data[4*k +: 4] = nib;
        wait_gnt(ok);
        if (!ok) begin
            timeout_fail({tag, "_gnt"});
            req = '0;
            return;
        end
        check({tag, "_gnt"}, 32'(gnt), 32'(1 << k));
        check({tag, "_res_a_t"}, 32'(res_a), 32'(nib));
        req[k] = 1'b0;
        req_data[4*k +: 4] = ~nib;
        @(negedge clk);
        check({tag, "_res_a_t1"}, 32'(res_a), 32'(nib));
        check({tag, "_early_rsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_x"}, 32'(rsp_x), 32'(exp_x));
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(k));
        @(negedge clk);
        check({tag, "_idle_after"}, {27'd0, busy, res_a}, 32'd0);
    endtask

    // scoreboard / main sequence
    initial begin
        logic [1:0] exp_g_q[$];
        logic [1:0] exp_id_q[$];
        logic       exp_x_q[$];
        logic [1:0] eg;
        bit         ok;
        int         ng;
        int         nr;
        int         last_g;

        for (int i = 0; i < 16; i++) begin
            vecs[i].nib   = 4'(i);
            vecs[i].exp_x = (i < 8) ? 1'b1 : 1'b0;
        end

        // reset and idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_quiet", {24'd0, busy, res_a, gnt, rsp_valid} & 32'h3ff, 32'd0);
        end

        // single request on requester 2, a[0]=1 -> x=0
        single(2, 4'b1010, 1'b0, "req2");

        // nibble sweep on requester 0
        for (int i = 0; i < 16; i++) begin
            single(0, vecs[i].nib, vecs[i].exp_x, $sformatf("sweep%0d", i));
        end

        // all four requesting: strict rotation from pointer 0, 3-cycle spacing
        do_reset();
        exp_g_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_id_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_x_q  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        req_data = {4'b1111, 4'b0111, 4'b1000, 4'b0001};
        req      = 4'b1111;
        ng = 0;
        nr = 0;
        last_g = 0;
        for (int cyc = 0; cyc < 60 && nr < 5; cyc++) begin
            @(negedge clk);
            if (gnt != '0) begin
                if (exp_g_q.size() == 0) begin
                    check("rot_extra_gnt", 32'(gnt), 32'd0);
                end else begin
                    eg = exp_g_q.pop_front();
                    check($sformatf("rot_gnt%0d", ng), 32'(gnt), 32'(1 << eg));
                end
                if (ng > 0) check($sformatf("rot_spacing%0d", ng), 32'(cyc - last_g), 32'd3);
                last_g = cyc;
                ng++;
                if (ng == 5) req = '0;
            end
            if (rsp_valid) begin
                if (exp_x_q.size() == 0) begin
                    check("rot_extra_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    check($sformatf("rot_rsp_id%0d", nr), 32'(rsp_id), 32'(exp_id_q.pop_front()));
                    check($sformatf("rot_rsp_x%0d", nr), 32'(rsp_x), 32'(exp_x_q.pop_front()));
                end
                nr++;
            end
        end
        if (nr < 5) timeout_fail("rot_responses");
        @(negedge clk);
        check("rot_idle", {31'd0, busy}, 32'd0);

        // asynchronous reset during WAIT drops the transaction
        req_data = 16'h0000;
        req      = 4'b0100;
        wait_gnt(ok);
        if (!ok) timeout_fail("rst_gnt");
        check("rst_pre_gnt", 32'(gnt), 32'b0100);
        req = 4'b1110;
        @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_res_a", 32'(res_a), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp", {30'd0, rsp_valid, rsp_x}, 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) check("rst_dropped_rsp", 32'(rsp_valid), 32'd0);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("rst_next_gnt");
        check("rst_next_gnt", 32'(gnt), 32'b0010);
        req = '0;
        repeat (4) @(negedge clk);

`ifdef NIBBLE_RES_ARBITER_STATS_EN
        // saturating grant counters
        do_reset();
        req_data = 16'h0000;
        req      = 4'b0010;
        ng = 0;
        for (int c = 0; c < 1200 && ng < 300; c++) begin
            @(negedge clk);
            if (gnt != '0) ng++;
        end
        req = '0;
        if (ng < 300) timeout_fail("stats_grants");
        repeat (5) @(negedge clk);
        check("stats_cnt1", 32'(grant_cnt[15:8]), 32'hFF);
        check("stats_cnt0", 32'(grant_cnt[7:0]), 32'd0);
        check("stats_cnt2", 32'(grant_cnt[23:16]), 32'd0);
        check("stats_cnt3", 32'(grant_cnt[31:24]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
